// File: rtl/t02_mem_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
//   mem_state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT -> DONE)
//   mem_src_t   : which requester owns the current transaction
//   mem_op_t    : RAM operation of the current transaction
//   streak_inc  : saturating increment for the data-grant streak counter
package t02_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } mem_src_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_t;

  localparam int TMO_CNT_W = 16;
  localparam int STREAK_W  = 8;

  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s,
                                                     input logic [STREAK_W-1:0] lim);
    return (s >= lim) ? lim : s + 1'b1;
  endfunction

endpackage

// File: rtl/t02_mem_arbiter_if.sv
// Bundle of every core-side and RAM-side signal of the memory arbiter.
//   core fetch side : i_req, i_addr -> i_rdata, i_ready
//   core data side  : d_ren, d_wen, d_addr, d_wdata -> d_rdata, d_ready
//   RAM side        : ramaddr, ramstore, Ren, Wen -> ramload, busy_o
//   control/status  : enable in, bus_err out
// Handshake: a requester raises i_req / d_ren / d_wen and holds it, with stable
// address and data, until its ready output pulses high for one cycle; the read
// data output is valid from that cycle on and is held until the next capture.
// On the RAM side Ren/Wen is a one-cycle strobe; the RAM answers by keeping
// busy_o high while working and lowering it when ramload is valid.
// modport master : arbiter view; modport slave : core + RAM environment view.
interface t02_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              enable;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_ren;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic              Ren;
  logic              Wen;
  logic [DATA_W-1:0] ramload;
  logic              busy_o;
  logic              bus_err;

  modport master (
    input  enable, i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ramload, busy_o,
    output i_rdata, i_ready, d_rdata, d_ready, ramaddr, ramstore, Ren, Wen, bus_err
  );

  modport slave (
    output enable, i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ramload, busy_o,
    input  i_rdata, i_ready, d_rdata, d_ready, ramaddr, ramstore, Ren, Wen, bus_err
  );
endinterface

// File: rtl/t02_mem_timeout.sv
// Saturating WAIT-cycle counter for the memory arbiter.
//   clk, nrst : clock, synchronous active-low reset
//   clear     : reload the count with zero (takes priority over en)
//   en        : count up by one, saturating at all-ones
//   count     : current count
//   expired   : count has reached LIMIT; never asserted when LIMIT = 0
module t02_mem_timeout import t02_mem_pkg::*; #(
  parameter int LIMIT = 255
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clear,
  input  logic                 en,
  output logic [TMO_CNT_W-1:0] count,
  output logic                 expired
);

  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && (count >= TMO_CNT_W'(LIMIT));

endmodule

// File: rtl/t02_mem_arbiter.sv
// Shares one RAM port between instruction fetch and data load/store.
//   clk, nrst : clock, synchronous active-low reset
//   bus       : core and RAM signals (see t02_mem_arbiter_if)
//   dbg_state : current FSM state, for observation only
// One transaction at a time: IDLE latches the winner, ISSUE strobes Ren/Wen for
// one cycle, WAIT holds address/data until the RAM drops busy_o (or the timeout
// fires), DONE pulses the winner's ready. All outputs come straight from flops.
module t02_mem_arbiter import t02_mem_pkg::*; #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  t02_mem_arbiter_if.master        bus,
  output mem_state_t               dbg_state
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  mem_state_t          state;
  mem_src_t            lat_src;
  mem_op_t             lat_op;
  logic [ADDR_W-1:0]   ramaddr_q;
  logic [DATA_W-1:0]   ramstore_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                ren_q;
  logic                wen_q;
  logic                i_ready_q;
  logic                d_ready_q;
  logic                bus_err_q;
  logic [STREAK_W-1:0] streak;

  logic [TMO_CNT_W-1:0] wait_cnt;
  logic                 tmo_expired;
  logic                 d_pending;
  logic                 fetch_forced;
  logic                 grant_d;
  logic                 settle;
  logic                 finish_ok;
  logic                 finish_tmo;
  logic [DATA_W-1:0]    cap_data;

  // The counter is zero on the first WAIT cycle, which doubles as the settle
  // marker: busy_o is not trusted until the RAM has seen the strobe.
  t02_mem_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (state != WAIT),
    .en      (state == WAIT),
    .count   (wait_cnt),
    .expired (tmo_expired)
  );

  // Data wins unless fetch is waiting and data already took MAX_D_STREAK
  // grants in a row.
  assign d_pending    = bus.d_ren | bus.d_wen;
  assign fetch_forced = bus.i_req && (streak >= STREAK_MAX);
  assign grant_d      = d_pending && !fetch_forced;

  assign settle     = (wait_cnt == '0);
  assign finish_ok  = (state == WAIT) && !settle && !bus.busy_o;
  assign finish_tmo = (state == WAIT) && !settle && bus.busy_o && tmo_expired;
  // An aborted read returns zero.
  assign cap_data   = finish_ok ? bus.ramload : '0;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      lat_src    <= SRC_I;
      lat_op     <= OP_RD;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      streak     <= '0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      if (!bus.i_req) streak <= '0;

      case (state)
        IDLE: begin
          if (bus.enable && (bus.i_req || d_pending)) begin
            state <= ISSUE;
            if (grant_d) begin
              lat_src    <= SRC_D;
              // read+write together is a write
              lat_op     <= bus.d_wen ? OP_WR : OP_RD;
              ramaddr_q  <= bus.d_addr;
              ramstore_q <= bus.d_wen ? bus.d_wdata : '0;
              ren_q      <= !bus.d_wen;
              wen_q      <= bus.d_wen;
              if (bus.i_req) streak <= streak_inc(streak, STREAK_MAX);
            end else begin
              lat_src    <= SRC_I;
              lat_op     <= OP_RD;
              ramaddr_q  <= bus.i_addr;
              ramstore_q <= '0;
              ren_q      <= 1'b1;
              wen_q      <= 1'b0;
              streak     <= '0;
            end
          end
        end
        ISSUE: begin
          ren_q <= 1'b0;
          wen_q <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (finish_ok || finish_tmo) begin
            state      <= DONE;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            if (finish_tmo) bus_err_q <= 1'b1;
            if (lat_src == SRC_I) begin
              i_ready_q <= 1'b1;
              i_rdata_q <= cap_data;
            end else begin
              d_ready_q <= 1'b1;
              if (lat_op == OP_RD) d_rdata_q <= cap_data;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ramaddr  = ramaddr_q;
  assign bus.ramstore = ramstore_q;
  assign bus.Ren      = ren_q;
  assign bus.Wen      = wen_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.i_ready  = i_ready_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_ready  = d_ready_q;
  assign bus.bus_err  = bus_err_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Bench for t02_mem_arbiter: directed scenarios plus random transactions,
// checked against a transaction-level reference model.
module tb_t02_mem_arbiter;
  import t02_mem_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TMO   = 8;
  localparam int MAXS  = 4;
  localparam int BOUND = 40;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       nrst;
  mem_state_t dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  t02_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  t02_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .MAX_D_STREAK(MAXS)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int            total = 0;
  int            bad   = 0;
  int            m_streak;
  logic [DW-1:0] m_i_rdata;
  logic [DW-1:0] m_d_rdata;
  logic          m_bus_err;
  logic [DW-1:0] exp_q[$];
  bit            won_d;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_streak  = 0;
    m_i_rdata = '0;
    m_d_rdata = '0;
    m_bus_err = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver: one complete transaction ----------------
  // Called at the start of an IDLE cycle; returns at the start of the next
  // IDLE cycle. busy_len = number of WAIT cycles (from the first) with busy_o=1.
  task automatic do_txn(input bit want_i, input bit want_rd, input bit want_wr,
                        input logic [AW-1:0] ia, input logic [AW-1:0] da,
                        input logic [DW-1:0] wd, input logic [DW-1:0] load,
                        input int busy_len, input bit drop_en);
    bit            win_d;
    bit            is_wr;
    bit            seen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_store;
    logic [DW-1:0] e_data;
    int            e_lat;

    // reference model
    win_d = (want_rd || want_wr) && !(want_i && (m_streak >= MAXS));
    is_wr = win_d && want_wr;
    if (win_d) begin
      if (want_i) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
    end else begin
      m_streak = 0;
    end
    if (!want_i) m_streak = 0;
    e_addr  = win_d ? da : ia;
    e_store = is_wr ? wd : '0;
    if (busy_len > TMO) begin
      // settle cycle plus TMO busy cycles, then abort
      e_lat     = 3 + TMO;
      e_data    = '0;
      m_bus_err = 1'b1;
    end else begin
      e_lat  = 3 + ((busy_len < 1) ? 1 : busy_len);
      e_data = load;
    end
    if (!is_wr) begin
      if (win_d) m_d_rdata = e_data;
      else       m_i_rdata = e_data;
    end
    exp_q.push_back(win_d ? m_d_rdata : m_i_rdata);

    // drive requests
    bus.enable  = 1'b1;
    bus.i_req   = want_i;
    bus.i_addr  = ia;
    bus.d_ren   = want_rd;
    bus.d_wen   = want_wr;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    bus.ramload = load;
    bus.busy_o  = 1'b0;
    seen = 1'b0;

    for (int c = 1; c <= BOUND && !seen; c++) begin
      step();
      if (drop_en && c == 1) bus.enable = 1'b0;
      bus.busy_o = (c >= 2) && ((c - 2) < busy_len);
      if (bus.i_ready || bus.d_ready) begin
        seen = 1'b1;
        check("latency", 64'(c), 64'(e_lat));
        check("ready_kind", {bus.i_ready, bus.d_ready}, win_d ? 2'b01 : 2'b10);
        check("win_rdata", win_d ? bus.d_rdata : bus.i_rdata, exp_q.pop_front());
        check("i_rdata", bus.i_rdata, m_i_rdata);
        check("d_rdata", bus.d_rdata, m_d_rdata);
        check("ramaddr_done", bus.ramaddr, 0);
        check("ramstore_done", bus.ramstore, 0);
        check("bus_err", bus.bus_err, m_bus_err);
        if (win_d) begin
          bus.d_ren = 1'b0;
          bus.d_wen = 1'b0;
        end else begin
          bus.i_req = 1'b0;
        end
        bus.enable = 1'b1;
        bus.busy_o = 1'b0;
      end else if (c == 1) begin
        check("ren_issue", bus.Ren, !is_wr);
        check("wen_issue", bus.Wen, is_wr);
        check("ramaddr_issue", bus.ramaddr, e_addr);
        check("ramstore_issue", bus.ramstore, e_store);
      end else begin
        check("strobes_wait", {bus.Ren, bus.Wen}, 2'b00);
        check("ramaddr_wait", bus.ramaddr, e_addr);
        check("ramstore_wait", bus.ramstore, e_store);
      end
    end
    if (!seen) begin
      check("ready_seen", 0, 1);
      exp_q.delete();
      bus.i_req  = 1'b0;
      bus.d_ren  = 1'b0;
      bus.d_wen  = 1'b0;
      bus.enable = 1'b1;
      bus.busy_o = 1'b0;
    end
    won_d = win_d;
    step();
    check("ready_pulse_width", {bus.i_ready, bus.d_ready}, 2'b00);
    check("back_to_idle", dbg_state, IDLE);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit ri;
    bit rr;
    bit rw;

    nrst        = 1'b0;
    bus.enable  = 1'b1;
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h40;
    bus.d_ren   = 1'b0;
    bus.d_wen   = 1'b1;
    bus.d_addr  = 32'h80;
    bus.d_wdata = 32'hFFFF_FFFF;
    bus.ramload = 32'h1234_5678;
    bus.busy_o  = 1'b0;
    model_reset();

    // reset dominates pending requests
    step();
    step();
    check("rst_state", dbg_state, IDLE);
    check("rst_ren", bus.Ren, 0);
    check("rst_wen", bus.Wen, 0);
    check("rst_ramaddr", bus.ramaddr, 0);
    check("rst_ramstore", bus.ramstore, 0);
    check("rst_i_ready", bus.i_ready, 0);
    check("rst_d_ready", bus.d_ready, 0);
    check("rst_i_rdata", bus.i_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_bus_err", bus.bus_err, 0);
    bus.i_req = 1'b0;
    bus.d_wen = 1'b0;
    nrst      = 1'b1;
    step();

    // fetch only, minimum latency
    do_txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 32'h00A0_0093, 0, 0);
    // load to give d_rdata a known value
    do_txn(0, 1, 0, 32'h0, 32'h3000, 32'h0, 32'h1234_5678, 1, 0);
    // store with busy_o high for 3 cycles; d_rdata must stay
    do_txn(0, 0, 1, 32'h0, 32'h2000, 32'hDEAD_BEEF, 32'hAAAA_5555, 3, 0);
    // read+write together behaves as a write
    do_txn(0, 1, 1, 32'h0, 32'h2004, 32'h0BAD_F00D, 32'h5555_AAAA, 0, 0);

    // contention: fetch and load held together -> D,D,D,D,I
    for (int k = 0; k < 5; k++) begin
      do_txn(1, 1, 0, 32'h500 + 32'(4 * k), 32'h600 + 32'(4 * k), 32'h0,
             32'h1000 + 32'(k), k % 3, 0);
      check("grant_order", won_d, (k < 4) ? 1'b1 : 1'b0);
    end

    // enable=0 blocks a pending fetch
    bus.enable = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h400;
    for (int k = 0; k < 6; k++) begin
      step();
      check("gated_ren", bus.Ren, 0);
      check("gated_state", dbg_state, IDLE);
    end
    do_txn(1, 0, 0, 32'h400, 32'h0, 32'h0, 32'h0C0F_FEE0, 0, 0);
    // enable dropped after the grant: transaction still completes
    do_txn(0, 1, 0, 32'h0, 32'h440, 32'h0, 32'h7777_1111, 4, 1);

    // random traffic, busy never long enough to abort
    for (int n = 0; n < 30; n++) begin
      ri = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      if (!ri && !rr && !rw) ri = 1'b1;
      do_txn(ri, rr, rw, $urandom, $urandom, $urandom, $urandom,
             $urandom_range(0, TMO), ($urandom_range(0, 3) == 0));
    end

    // timeout with busy stuck high
    do_txn(0, 1, 0, 32'h0, 32'h6000, 32'h0, 32'hCAFE_F00D, 2, 0);
    do_txn(0, 1, 0, 32'h0, 32'h7000, 32'h0, 32'h55AA_55AA, 1000, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bus_err_sticky", bus.bus_err, 1);
    end
    do_txn(1, 0, 0, 32'h800, 32'h0, 32'h0, 32'h1357_9BDF, 1, 0);

    // reset in the middle of WAIT
    bus.enable  = 1'b1;
    bus.d_wen   = 1'b1;
    bus.d_addr  = 32'h9000;
    bus.d_wdata = 32'h2468_ACE0;
    bus.busy_o  = 1'b1;
    step();
    check("mid_wen", bus.Wen, 1);
    step();
    step();
    check("mid_in_wait", dbg_state, WAIT);
    nrst       = 1'b0;
    bus.d_wen  = 1'b0;
    bus.busy_o = 1'b0;
    step();
    model_reset();
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_strobes", {bus.Ren, bus.Wen}, 2'b00);
    check("mid_rst_ready", {bus.i_ready, bus.d_ready}, 2'b00);
    check("mid_rst_ramaddr", bus.ramaddr, 0);
    check("mid_rst_bus_err", bus.bus_err, 0);
    check("mid_rst_d_rdata", bus.d_rdata, 0);
    nrst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("post_rst_no_ready", {bus.i_ready, bus.d_ready}, 2'b00);
      check("post_rst_idle", dbg_state, IDLE);
    end
    do_txn(1, 0, 0, 32'hA00, 32'h0, 32'h0, 32'h0000_0013, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
